qsysdemo_ram_loader: RTL and testbench

- Upstream feeder for the Nios on-chip program/data RAM (32-bit, byte-enabled, single-port, 5120 words).
- Accepts a byte stream (valid/ready), packs bytes little-endian into 32-bit words, and writes them through the RAM's second Avalon slave port, starting at a programmable word address.
- Used to boot-load or patch RAM contents without involving the CPU.
- Optional read-back checksum verify.

---
 rtl/qsysdemo_ram_loader.sv | 192 +++++++++++++++++++
 tb/tb_qsysdemo_ram_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/qsysdemo_ram_loader.sv
// Byte-stream to 32-bit RAM loader: packs bytes little-endian and writes them through the RAM's Avalon port.
// Optional read-back checksum verify when QSYSDEMO_RAM_LOADER_VERIFY_EN is defined.
module qsysdemo_ram_loader #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 5120
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_eop,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [3:0]        ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [31:0]       ram_writedata,
    output logic              ram_clken,
    input  logic [31:0]       ram_readdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              wrap_err,
    output logic              verify_err
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_VERIFY, S_VCHK, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr, r_base;
    logic [31:0]       r_acc, r_wr_data, r_wsum;
    logic [1:0]        r_idx;
    logic [3:0]        r_wr_be, r_last_be;
    logic              r_wr_vld, r_clken, r_wrap_err;
    logic [ADDR_W:0]   r_word_cnt;
    logic              w_accept, w_word_end;
    logic [31:0]       w_word;
    logic [3:0]        w_be;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_ONE;
    endfunction

    assign w_accept   = in_valid && (r_state == S_LOAD);
    assign w_word_end = w_accept && ((r_idx == 2'd3) || in_eop);

    always_comb begin
        w_word = r_acc;
        w_word[{r_idx, 3'b000} +: 8] = in_data;
        case (r_idx)
            2'd0:    w_be = 4'b0001;
            2'd1:    w_be = 4'b0011;
            2'd2:    w_be = 4'b0111;
            default: w_be = 4'b1111;
        endcase
    end

`ifdef QSYSDEMO_RAM_LOADER_VERIFY_EN
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W:0]   r_rd_idx;
    logic [31:0]       r_rsum, w_rmask, w_rsum_final;
    logic              r_rd_pend, r_verify_err, w_rd_act;

    assign w_rd_act     = (r_state == S_VERIFY);
    assign w_rmask      = {{8{r_last_be[3]}}, {8{r_last_be[2]}}, {8{r_last_be[1]}}, {8{r_last_be[0]}}};
    // The last read lands during VCHK; only its written lanes count towards the sum.
    assign w_rsum_final = r_rsum + (ram_readdata & w_rmask);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_addr    <= '0;
            r_rd_idx     <= '0;
            r_rsum       <= '0;
            r_rd_pend    <= 1'b0;
            r_verify_err <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_act;
            case (r_state)
                S_IDLE:   if (start) r_verify_err <= 1'b0;
                S_DRAIN: begin
                    r_rd_addr <= r_base;
                    r_rd_idx  <= '0;
                    r_rsum    <= '0;
                end
                S_VERIFY: begin
                    r_rd_addr <= addr_inc(r_rd_addr);
                    r_rd_idx  <= r_rd_idx + CNT_ONE;
                    if (r_rd_pend) r_rsum <= r_rsum + ram_readdata;
                end
                S_VCHK:   if (w_rsum_final != r_wsum) r_verify_err <= 1'b1;
                default:  ;
            endcase
        end
    end

    assign ram_chipselect = r_wr_vld || w_rd_act;
    assign ram_address    = w_rd_act ? r_rd_addr : r_addr;
    assign ram_byteenable = w_rd_act ? 4'hF : (r_wr_vld ? r_wr_be : 4'h0);
    assign verify_err     = r_verify_err;
`else
    logic w_unused;
    assign w_unused       = ^{ram_readdata, r_base, r_last_be};
    assign ram_chipselect = r_wr_vld;
    assign ram_address    = r_addr;
    assign ram_byteenable = r_wr_vld ? r_wr_be : 4'h0;
    assign verify_err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_LOAD;
            S_LOAD:   if (w_accept && in_eop) w_next = S_DRAIN;
`ifdef QSYSDEMO_RAM_LOADER_VERIFY_EN
            S_DRAIN:  w_next = S_VERIFY;
            S_VERIFY: if ((r_rd_idx + CNT_ONE) == r_word_cnt) w_next = S_VCHK;
`else
            S_DRAIN:  w_next = S_DONE;
            S_VERIFY: w_next = S_IDLE;
`endif
            S_VCHK:   w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clken    <= 1'b0;
            r_addr     <= '0;
            r_base     <= '0;
            r_acc      <= '0;
            r_idx      <= '0;
            r_wr_vld   <= 1'b0;
            r_wr_data  <= '0;
            r_wr_be    <= '0;
            r_last_be  <= '0;
            r_word_cnt <= '0;
            r_wsum     <= '0;
            r_wrap_err <= 1'b0;
        end else begin
            r_clken  <= 1'b1;
            r_wr_vld <= w_word_end;
            if (r_state == S_IDLE && start) begin
                r_addr     <= base_addr;
                r_base     <= base_addr;
                r_acc      <= '0;
                r_idx      <= '0;
                r_word_cnt <= '0;
                r_wsum     <= '0;
                r_wrap_err <= 1'b0;
            end
            if (w_accept) begin
                if (w_word_end) begin
                    r_wr_data <= w_word;
                    r_wr_be   <= w_be;
                    r_acc     <= '0;
                    r_idx     <= '0;
                    if (in_eop) r_last_be <= w_be;
                end else begin
                    r_acc <= w_word;
                    r_idx <= r_idx + 2'd1;
                end
            end
            if (r_wr_vld) begin
                r_addr     <= addr_inc(r_addr);
                r_word_cnt <= r_word_cnt + CNT_ONE;
                r_wsum     <= r_wsum + r_wr_data;
                if (r_addr == LAST_ADDR) r_wrap_err <= 1'b1;
            end
        end
    end

    assign in_ready      = (r_state == S_LOAD);
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign ram_write     = r_wr_vld;
    assign ram_writedata = r_wr_data;
    assign ram_clken     = r_clken;
    assign word_count    = r_word_cnt;
    assign wrap_err      = r_wrap_err;
endmodule

// File: tb/tb_qsysdemo_ram_loader.sv
// Self-checking bench for qsysdemo_ram_loader: directed vector table, reset corner, randomized loads vs. a word-level model.
module tb_qsysdemo_ram_loader;
    localparam int DEPTH = 5120;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [12:0] base_addr = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0, in_eop = 1'b0;
    logic        in_ready, ram_chipselect, ram_write, ram_clken, busy, done, wrap_err, verify_err;
    logic [12:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata = '0;
    logic [13:0] word_count;

    qsysdemo_ram_loader #(.ADDR_W(13), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_data(in_data), .in_valid(in_valid), .in_eop(in_eop), .in_ready(in_ready),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata),
        .busy(busy), .done(done), .word_count(word_count),
        .wrap_err(wrap_err), .verify_err(verify_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct { logic [12:0] a; logic [31:0] d; logic [3:0] be; } wr_t;

    // RAM model: byte-enabled writes, one-cycle read latency, optional single-word read corruption
    logic [31:0] mem [DEPTH];
    wr_t         got[$];
    bit          corrupt = 1'b0;
    logic [12:0] corrupt_addr = '0;

    always @(negedge clk) begin
        if (!reset && ram_chipselect && ram_write) begin
            got.push_back('{ram_address, ram_writedata, ram_byteenable});
            for (int l = 0; l < 4; l++)
                if (ram_byteenable[l]) mem[ram_address][8*l +: 8] = ram_writedata[8*l +: 8];
        end
    end

    always @(posedge clk) begin
        if (ram_chipselect && !ram_write)
            ram_readdata <= mem[ram_address] ^ ((corrupt && ram_address == corrupt_addr) ? 32'h100 : 32'h0);
    end

    task automatic model(input logic [12:0] base, input logic [7:0] bytes[$], output wr_t exp[$], output bit wrap);
        int n, nw;
        exp.delete();
        wrap = 1'b0;
        n  = bytes.size();
        nw = (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            wr_t e;
            e.a  = 13'((int'(base) + w) % DEPTH);
            e.d  = '0;
            e.be = '0;
            for (int l = 0; l < 4; l++)
                if (4*w + l < n) begin
                    e.d  = e.d | (32'(bytes[4*w + l]) << (8*l));
                    e.be[l] = 1'b1;
                end
            if (int'(e.a) == DEPTH - 1) wrap = 1'b1;
            exp.push_back(e);
        end
    endtask

    task automatic run_load(input string tag, input logic [12:0] base, input logic [7:0] bytes[$],
                            input int gap_pct, input bit noise, input bit exp_verr);
        wr_t exp[$];
        bit  wrap;
        int  n;
        model(base, bytes, exp, wrap);
        n = bytes.size();
        got.delete();
        @(negedge clk);
        start = 1'b1;
        base_addr = base;
        @(negedge clk);
        start = 1'b0;
        base_addr = 13'($urandom);
        check($sformatf("%s ready_in_load", tag), in_ready, 1'b1);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                start = noise ? 1'($urandom) : 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = bytes[i];
            in_eop   = (i == n - 1);
            start    = (noise && i != n - 1) ? 1'($urandom) : 1'b0;
            base_addr = 13'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_eop   = 1'b0;
        start    = 1'b0;
        check($sformatf("%s ready_after_eop", tag), in_ready, 1'b0);
`ifdef QSYSDEMO_RAM_LOADER_VERIFY_EN
        for (int c = 0; c < 200 && !done; c++) @(negedge clk);
        check($sformatf("%s done_seen", tag), done, 1'b1);
`else
        check($sformatf("%s done_early", tag), done, 1'b0);
        @(negedge clk);
        check($sformatf("%s done_at_2", tag), done, 1'b1);
`endif
        check($sformatf("%s busy_in_done", tag), busy, 1'b1);
        check($sformatf("%s word_count", tag), word_count, 14'(exp.size()));
        check($sformatf("%s wrap_err", tag), wrap_err, wrap);
        check($sformatf("%s verify_err", tag), verify_err, exp_verr);
        check($sformatf("%s n_writes", tag), got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s write%0d {a,d,be}", tag, i), {got[i].a, got[i].d, got[i].be},
                  {exp[i].a, exp[i].d, exp[i].be});
        @(negedge clk);
        check($sformatf("%s done_pulse_end", tag), {done, busy}, 2'b00);
        check($sformatf("%s word_count_held", tag), word_count, 14'(exp.size()));
    endtask

    typedef struct {
        logic [12:0] base; int nbytes; logic [7:0] b0;
        int exp_wc; bit exp_wrap; logic [12:0] last_a; logic [31:0] last_d; logic [3:0] last_be;
    } vec_t;

    function automatic void make_bytes(input vec_t v, output logic [7:0] q[$]);
        q.delete();
        for (int k = 0; k < v.nbytes; k++) q.push_back(8'(v.b0 + 8'(8'h11 * k)));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[6];
        logic [7:0]  q[$];
        logic [12:0] b;

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        vecs[0] = '{13'h010, 8, 8'h11, 2, 1'b0, 13'h011, 32'h88776655, 4'hF};
        vecs[1] = '{13'h020, 5, 8'hAA, 2, 1'b0, 13'h021, 32'h000000EE, 4'h1};
        vecs[2] = '{13'd5119, 8, 8'h11, 2, 1'b1, 13'h000, 32'h88776655, 4'hF};
        vecs[3] = '{13'h100, 3, 8'h01, 1, 1'b0, 13'h100, 32'h00231201, 4'h7};
        vecs[4] = '{13'h000, 1, 8'h5A, 1, 1'b0, 13'h000, 32'h0000005A, 4'h1};
        vecs[5] = '{13'd5118, 6, 8'h10, 2, 1'b1, 13'd5119, 32'h00006554, 4'h3};

        #2;
        check("in_reset outputs", {in_ready, ram_chipselect, ram_write, ram_clken, busy, done,
              wrap_err, verify_err, ram_address, ram_byteenable, ram_writedata, word_count}, '0);
        @(negedge clk);
        reset = 1'b0;
        check("clken_low_at_release", ram_clken, 1'b0);
        @(negedge clk);
        check("clken_after_reset", ram_clken, 1'b1);
        check("idle outputs", {in_ready, ram_chipselect, ram_write, busy, done, wrap_err,
              verify_err, ram_address, ram_byteenable, ram_writedata, word_count}, '0);

        for (int i = 0; i < 6; i++) begin
            make_bytes(vecs[i], q);
            run_load($sformatf("vec%0d", i), vecs[i].base, q, 0, 1'b0, 1'b0);
            check($sformatf("vec%0d table_wc", i), word_count, 14'(vecs[i].exp_wc));
            check($sformatf("vec%0d table_wrap", i), wrap_err, vecs[i].exp_wrap);
            if (got.size() > 0)
                check($sformatf("vec%0d table_last", i),
                      {got[got.size()-1].a, got[got.size()-1].d, got[got.size()-1].be},
                      {vecs[i].last_a, vecs[i].last_d, vecs[i].last_be});
            else
                check($sformatf("vec%0d table_last_missing", i), 0, 1);
        end

        // Reset after two bytes of a load: nothing may reach the RAM
        got.delete();
        @(negedge clk);
        start = 1'b1;
        base_addr = 13'h200;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hC0 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midreset busy/ready/write", {busy, in_ready, ram_write, ram_chipselect}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("midreset no_write", got.size(), 0);
        check("midreset clken", ram_clken, 1'b1);
        make_bytes(vecs[0], q);
        run_load("after_reset", vecs[0].base, q, 0, 1'b0, 1'b0);

`ifdef QSYSDEMO_RAM_LOADER_VERIFY_EN
        q.delete();
        for (int k = 0; k < 12; k++) q.push_back(8'($urandom));
        run_load("verify_clean", 13'h300, q, 0, 1'b0, 1'b0);
        corrupt = 1'b1;
        corrupt_addr = 13'h301;
        run_load("verify_corrupt", 13'h300, q, 0, 1'b0, 1'b1);
        corrupt = 1'b0;
        run_load("verify_cleared", 13'd5118, q, 20, 1'b0, 1'b0);
`endif

        for (int t = 0; t < 25; t++) begin
            q.delete();
            for (int k = 0, n = $urandom_range(1, 24); k < n; k++) q.push_back(8'($urandom));
            b = ($urandom_range(1) == 1) ? 13'(DEPTH - 1 - $urandom_range(0, 5)) : 13'($urandom_range(0, DEPTH - 1));
            run_load($sformatf("rand%0d", t), b, q, 30, 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
